// File: rtl/dds_axil_regs.sv
// dds_axil_regs: AXI4-Lite register file holding the DDS control word (CTRL),
// frequency tuning word (FTW), phase offset word (POW) and a scratch register.
// Ports: S_AXI_* = AXI4-Lite slave (AW/W/B write path, AR/R read path, ACLK,
//        sync active-low ARESETN); dds_enable/dds_ftw/dds_pow = register flops
//        driven to the datapath; dds_update = 1-cycle pulse when FTW/POW change.
module dds_axil_regs #(
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int C_S_AXI_DATA_WIDTH = 32
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic                            dds_enable,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   dds_ftw,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   dds_pow,
    output logic                            dds_update
);
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int SW = DW / 8;

    typedef enum logic {W_COLLECT = 1'b0, W_RESP = 1'b1} wstate_t;
    typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_t;

    logic [DW-1:0] regs [4];

    // ---------------- write channel ----------------
    wstate_t       wstate, wstate_nxt;
    logic          aw_done, w_done, aw_done_nxt, w_done_nxt;
    logic          awready_nxt, wready_nxt, bvalid_nxt;
    logic [1:0]    aw_idx;
    logic [DW-1:0] wdata_q;
    logic [SW-1:0] wstrb_q;
    logic          aw_hs, w_hs, b_hs, commit;
    logic [1:0]    wr_idx;
    logic [DW-1:0] wr_data;
    logic [SW-1:0] wr_strb;

    assign aw_hs  = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_hs   = S_AXI_WVALID & S_AXI_WREADY;
    assign b_hs   = S_AXI_BVALID & S_AXI_BREADY;
    assign commit = (wstate == W_COLLECT) & (aw_done | aw_hs) & (w_done | w_hs);

    // Whichever half arrives on the committing edge comes straight from the bus.
    assign wr_idx  = aw_done ? aw_idx  : S_AXI_AWADDR[3:2];
    assign wr_data = w_done  ? wdata_q : S_AXI_WDATA;
    assign wr_strb = w_done  ? wstrb_q : S_AXI_WSTRB;

    always_comb begin
        wstate_nxt = wstate;
        case (wstate)
            W_COLLECT: if (commit) wstate_nxt = W_RESP;
            W_RESP:    if (b_hs)   wstate_nxt = W_COLLECT;
            default:   wstate_nxt = W_COLLECT;
        endcase
    end

    // READY/VALID are registered so that they are all low while in reset.
    always_comb begin
        aw_done_nxt = 1'b0;
        w_done_nxt  = 1'b0;
        if (wstate == W_COLLECT && !commit) begin
            aw_done_nxt = aw_done | aw_hs;
            w_done_nxt  = w_done | w_hs;
        end
        awready_nxt = (wstate_nxt == W_COLLECT) & ~aw_done_nxt;
        wready_nxt  = (wstate_nxt == W_COLLECT) & ~w_done_nxt;
        bvalid_nxt  = (wstate_nxt == W_RESP);
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            wstate        <= W_COLLECT;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            aw_idx        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
        end else begin
            wstate        <= wstate_nxt;
            aw_done       <= aw_done_nxt;
            w_done        <= w_done_nxt;
            S_AXI_AWREADY <= awready_nxt;
            S_AXI_WREADY  <= wready_nxt;
            S_AXI_BVALID  <= bvalid_nxt;
            if (aw_hs) aw_idx <= S_AXI_AWADDR[3:2];
            if (w_hs) begin
                wdata_q <= S_AXI_WDATA;
                wstrb_q <= S_AXI_WSTRB;
            end
        end
    end

    // ---------------- register file ----------------
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            for (int r = 0; r < 4; r++) regs[r] <= '0;
            dds_update <= 1'b0;
        end else begin
            // Pulse lands in the same cycle the new FTW/POW value appears.
            dds_update <= commit & ((wr_idx == 2'd1) | (wr_idx == 2'd2));
            if (commit) begin
                for (int i = 0; i < SW; i++) begin
                    if (wr_strb[i]) regs[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    assign S_AXI_BRESP = 2'b00;
    assign dds_enable  = regs[0][0];
    assign dds_ftw     = regs[1];
    assign dds_pow     = regs[2];

    // ---------------- read channel ----------------
    rstate_t rstate, rstate_nxt;
    logic    ar_hs, arready_nxt, rvalid_nxt;

    assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;

    always_comb begin
        rstate_nxt = rstate;
        case (rstate)
            R_IDLE:  if (ar_hs)        rstate_nxt = R_DATA;
            R_DATA:  if (S_AXI_RREADY) rstate_nxt = R_IDLE;
            default: rstate_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        arready_nxt = (rstate_nxt == R_IDLE);
        rvalid_nxt  = (rstate_nxt == R_DATA);
    end

    // RDATA samples the pre-commit value when a write lands on the same edge.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            rstate        <= R_IDLE;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
        end else begin
            rstate        <= rstate_nxt;
            S_AXI_ARREADY <= arready_nxt;
            S_AXI_RVALID  <= rvalid_nxt;
            if (ar_hs) S_AXI_RDATA <= regs[S_AXI_ARADDR[3:2]];
        end
    end

    assign S_AXI_RRESP = 2'b00;

    // Only ADDR[3:2] selects a register; the remaining address bits are ignored.
    logic unused_addr;
    assign unused_addr = ^{S_AXI_AWADDR, S_AXI_ARADDR};

endmodule

// File: tb/tb_dds_axil_regs.sv
// tb_dds_axil_regs: directed bench for dds_axil_regs. A vector table drives
// single AXI-Lite writes/reads with hand-computed results; short hand-written
// sequences cover write ordering, B/R backpressure, update pulse and reset.
module tb_dds_axil_regs;
    logic        clk = 1'b0;
    logic        arst_n;
    logic [3:0]  awaddr, araddr;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata, ftw, pow;
    logic        en, upd;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dds_axil_regs dut (
        .ACLK(clk), .ARESETN(arst_n),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid),
        .S_AXI_WREADY(wready), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid),
        .S_AXI_BREADY(bready), .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid),
        .S_AXI_ARREADY(arready), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
        .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .dds_enable(en), .dds_ftw(ftw), .dds_pow(pow), .dds_update(upd)
    );

    // dds_update monitor: pulse count, longest run, FTW during and before pulse.
    int          upd_cnt = 0, upd_run = 0, upd_max = 0;
    logic [31:0] prev_ftw = '0, upd_ftw = '0, upd_prev = '0;
    always @(negedge clk) begin
        if (upd === 1'b1) begin
            upd_cnt++;
            upd_run++;
            if (upd_run > upd_max) upd_max = upd_run;
            upd_ftw  = ftw;
            upd_prev = prev_ftw;
        end else begin
            upd_run = 0;
        end
        prev_ftw = ftw;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic axi_write(input logic [3:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [1:0] resp);
        bit aw_p, w_p;
        int n;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1;
        aw_p = 1'b1; w_p = 1'b1; n = 0;
        while ((aw_p || w_p) && n < 50) begin
            bit af, wf;
            af = aw_p && awready;
            wf = w_p && wready;
            @(negedge clk); n++;
            if (af) begin awvalid = 1'b0; aw_p = 1'b0; end
            if (wf) begin wvalid = 1'b0; w_p = 1'b0; end
        end
        check("wr_addr_data_timeout", 32'(aw_p | w_p), 32'd0);
        awvalid = 1'b0; wvalid = 1'b0;
        bready = 1'b1; n = 0;
        while (bvalid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        check("wr_resp_timeout", 32'(bvalid !== 1'b1), 32'd0);
        resp = bresp;
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [3:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n;
        bit fired;
        araddr = a; arvalid = 1'b1; n = 0; fired = 1'b0;
        while (!fired && n < 50) begin
            fired = (arready === 1'b1);
            @(negedge clk); n++;
        end
        arvalid = 1'b0;
        check("rd_addr_timeout", 32'(!fired), 32'd0);
        n = 0;
        while (rvalid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        check("rd_data_timeout", 32'(rvalid !== 1'b1), 32'd0);
        d = rdata; resp = rresp;
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
    endtask

    typedef struct {
        bit          wr;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_rd;
        logic        exp_en;
        logic [31:0] exp_ftw;
        logic [31:0] exp_pow;
    } vec_t;

    vec_t vecs [17];

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        int          u0;

        vecs[0]  = '{1'b1, 4'h0, 32'h1,        4'hF, 32'h0,        1'b1, 32'h0,        32'h0};
        vecs[1]  = '{1'b1, 4'h4, 32'h2,        4'hF, 32'h0,        1'b1, 32'h2,        32'h0};
        vecs[2]  = '{1'b1, 4'h8, 32'h3,        4'hF, 32'h0,        1'b1, 32'h2,        32'h3};
        vecs[3]  = '{1'b1, 4'hC, 32'h4,        4'hF, 32'h0,        1'b1, 32'h2,        32'h3};
        vecs[4]  = '{1'b0, 4'h0, 32'h0,        4'h0, 32'h1,        1'b1, 32'h2,        32'h3};
        vecs[5]  = '{1'b0, 4'h4, 32'h0,        4'h0, 32'h2,        1'b1, 32'h2,        32'h3};
        vecs[6]  = '{1'b0, 4'h8, 32'h0,        4'h0, 32'h3,        1'b1, 32'h2,        32'h3};
        vecs[7]  = '{1'b0, 4'hC, 32'h0,        4'h0, 32'h4,        1'b1, 32'h2,        32'h3};
        vecs[8]  = '{1'b1, 4'h4, 32'h11223344, 4'hF, 32'h0,        1'b1, 32'h11223344, 32'h3};
        vecs[9]  = '{1'b1, 4'h6, 32'hAABBCCDD, 4'h2, 32'h0,        1'b1, 32'h1122CC44, 32'h3};
        vecs[10] = '{1'b0, 4'h5, 32'h0,        4'h0, 32'h1122CC44, 1'b1, 32'h1122CC44, 32'h3};
        vecs[11] = '{1'b1, 4'h1, 32'hFFFFFF00, 4'hF, 32'h0,        1'b0, 32'h1122CC44, 32'h3};
        vecs[12] = '{1'b0, 4'h0, 32'h0,        4'h0, 32'hFFFFFF00, 1'b0, 32'h1122CC44, 32'h3};
        vecs[13] = '{1'b1, 4'hC, 32'h12345678, 4'h0, 32'h0,        1'b0, 32'h1122CC44, 32'h3};
        vecs[14] = '{1'b0, 4'hF, 32'h0,        4'h0, 32'h4,        1'b0, 32'h1122CC44, 32'h3};
        vecs[15] = '{1'b1, 4'h8, 32'hDEADBEEF, 4'hC, 32'h0,        1'b0, 32'h1122CC44, 32'hDEAD0003};
        vecs[16] = '{1'b0, 4'h8, 32'h0,        4'h0, 32'hDEAD0003, 1'b0, 32'h1122CC44, 32'hDEAD0003};

        arst_n = 1'b0;
        awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_readies", 32'({awready, wready, arready}), 32'd0);
        check("rst_valids",  32'({bvalid, rvalid}), 32'd0);
        check("rst_rdata",   rdata, 32'd0);
        check("rst_dds",     32'({en, upd}) | ftw | pow, 32'd0);
        arst_n = 1'b1;
        @(negedge clk);
        check("post_rst_readies", 32'({awready, wready, arready}), 32'h7);

        // Table-driven single transactions
        for (int i = 0; i < 17; i++) begin
            if (vecs[i].wr) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, r);
                check($sformatf("v%0d_bresp", i), 32'(r), 32'd0);
            end else begin
                axi_read(vecs[i].addr, d, r);
                check($sformatf("v%0d_rdata", i), d, vecs[i].exp_rd);
                check($sformatf("v%0d_rresp", i), 32'(r), 32'd0);
            end
            check($sformatf("v%0d_en", i),  32'(en), 32'(vecs[i].exp_en));
            check($sformatf("v%0d_ftw", i), ftw, vecs[i].exp_ftw);
            check($sformatf("v%0d_pow", i), pow, vecs[i].exp_pow);
        end

        // dds_update: none for CTRL, one single-cycle pulse per FTW write
        u0 = upd_cnt;
        axi_write(4'h0, 32'h5, 4'hF, r);
        check("upd_ctrl_none", 32'(upd_cnt - u0), 32'd0);
        axi_write(4'h4, 32'h11223344, 4'hF, r);
        axi_write(4'h4, 32'hAABBCCDD, 4'h2, r);
        @(negedge clk);
        check("upd_count",    32'(upd_cnt - u0), 32'd2);
        check("upd_width",    32'(upd_max), 32'd1);
        check("upd_new_ftw",  upd_ftw, 32'h1122CC44);
        check("upd_prev_ftw", upd_prev, 32'h11223344);

        // W arrives 3 cycles ahead of AW
        wdata = 32'hCAFE0001; wstrb = 4'hF; wvalid = 1'b1;
        check("wfirst_wready", 32'(wready), 32'd1);
        @(negedge clk);
        wvalid = 1'b0;
        check("wfirst_wready_drop", 32'({wready, bvalid}), 32'd0);
        repeat (2) begin
            @(negedge clk);
            check("wfirst_wait", 32'({bvalid, awready}), 32'h1);
        end
        awaddr = 4'hC; awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        check("wfirst_bvalid", 32'({bvalid, awready, wready}), 32'h4);
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        check("wfirst_bclear", 32'(bvalid), 32'd0);
        axi_read(4'hC, d, r);
        check("wfirst_data", d, 32'hCAFE0001);

        // B backpressure with a second write queued behind it
        awaddr = 4'h8; wdata = 32'h55; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        check("bp_bvalid", 32'(bvalid), 32'd1);
        wdata = 32'h66;
        for (int k = 0; k < 5; k++) begin
            check("bp_hold", 32'({bvalid, awready, wready}), 32'h4);
            check("bp_pow_old", pow, 32'h55);
            @(negedge clk);
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        check("bp_after_b", 32'({bvalid, awready, wready}), 32'h3);
        check("bp_pow_still_old", pow, 32'h55);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        check("bp_second_b", 32'(bvalid), 32'd1);
        check("bp_pow_new", pow, 32'h66);
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;

        // R backpressure: RDATA held while RREADY low
        araddr = 4'h8; arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("rbp_rvalid", 32'({rvalid, arready}), 32'h2);
            check("rbp_rdata", rdata, 32'h66);
            @(negedge clk);
        end
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        check("rbp_rclear", 32'(rvalid), 32'd0);

        // Reset while BVALID pending
        awaddr = 4'h4; wdata = 32'h99; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        check("rst_mid_bvalid", 32'(bvalid), 32'd1);
        arst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_valids", 32'({bvalid, awready, wready, arready}), 32'd0);
        check("rst_mid_regs", ftw | pow | 32'(en), 32'd0);
        arst_n = 1'b1;
        @(negedge clk);
        axi_read(4'h0, d, r);
        check("rst_mid_ctrl", d, 32'd0);
        axi_read(4'hC, d, r);
        check("rst_mid_scratch", d, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

endmodule
